csr_access_unit: RTL

Initiator side of the CSR access interface. Accepts one decoded SYSTEM/Zicsr instruction at a time from the execute stage and drives number/access_type/in into the CSR register file. Captures the old CSR value from the register file and returns it, with the destination register, to writeback through a valid/ready response.
- Guarantees at most one write strobe (non-read-only access_type) per instruction.
- Flags illegal CSR instructions without writing.

---
 rtl/csr_access_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/csr_access_unit.sv
// csr_access_unit
//   Initiator side of the CSR access interface. Takes one decoded
//   SYSTEM/Zicsr instruction at a time, drives a single CSR access
//   (number / access_type / in) into the CSR register file, captures the
//   pre-write CSR value and returns it with rd through a valid/ready response.
//   Sequence per instruction: IDLE (accept) -> ACCESS (one cycle) -> RESPOND.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   req_valid/req_ready request handshake
//   req_instr           full RV32 instruction word
//   req_rs1_value       value of register rs1
//   csr_number          CSR address to the register file
//   csr_access_type     READ_ONLY / WRITE / SET / CLEAR strobe encoding
//   csr_in              write operand to the register file
//   csr_out             combinational read data from the register file
//   rsp_valid/rsp_ready response handshake
//   rsp_rd, rsp_data    destination register and old CSR value
//   rsp_illegal         illegal-instruction indication
//
// Parameters
//   RSP_DATA_ON_ILLEGAL value returned on rsp_data when rsp_illegal=1
//
// Optional build macro
//   CSR_UNIMPL_TRAP_EN  when defined, any CSR number outside the implemented
//                       set is illegal for both read and write.
//
// access_type encoding (matches csr_register.h):
//   00 READ_ONLY, 01 WRITE, 10 SET, 11 CLEAR

module csr_access_unit #(
  parameter logic [31:0] RSP_DATA_ON_ILLEGAL = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_instr,
  input  logic [31:0] req_rs1_value,
  output logic [11:0] csr_number,
  output logic [1:0]  csr_access_type,
  output logic [31:0] csr_in,
  input  logic [31:0] csr_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [4:0]  rsp_rd,
  output logic [31:0] rsp_data,
  output logic        rsp_illegal
);

  localparam logic [1:0] CSR_READ_ONLY = 2'b00;
  localparam logic [1:0] CSR_WRITE     = 2'b01;
  localparam logic [1:0] CSR_SET       = 2'b10;
  localparam logic [1:0] CSR_CLEAR     = 2'b11;

  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPOND
  } state_t;

  state_t      state;
  logic [6:0]  opcode_q;
  logic [1:0]  kind_q;     // funct3[1:0]: 01 write, 10 set, 11 clear, 00 invalid
  logic [4:0]  rs1_q;

  logic [1:0]  raw_type;
  logic        illegal;
  logic        implemented;

  // Requested operation before the legality check. Set/clear with rs1
  // field zero is a pure read and never counts as a write attempt.
  always_comb begin
    raw_type = CSR_READ_ONLY;
    case (kind_q)
      2'b01:   raw_type = CSR_WRITE;
      2'b10:   raw_type = (rs1_q == '0) ? CSR_READ_ONLY : CSR_SET;
      2'b11:   raw_type = (rs1_q == '0) ? CSR_READ_ONLY : CSR_CLEAR;
      default: raw_type = CSR_READ_ONLY;
    endcase
  end

  always_comb begin
    implemented = 1'b0;
    case (csr_number)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h341,
      12'hF11, 12'hF12, 12'hF13, 12'hF14: implemented = 1'b1;
      default:                            implemented = 1'b0;
    endcase
  end

  always_comb begin
    illegal = (opcode_q != OPCODE_SYSTEM)
           || (kind_q == 2'b00)
           || ((raw_type != CSR_READ_ONLY) && (csr_number[11:10] == 2'b11));
`ifdef CSR_UNIMPL_TRAP_EN
    if (!implemented) illegal = 1'b1;
`else
    if (implemented) illegal = illegal;
`endif
  end

  // Decoded from state, not registered, so a reset during ACCESS removes
  // the write strobe before the register file's commit edge.
  always_comb begin
    csr_access_type = CSR_READ_ONLY;
    if (state == ACCESS && !illegal) csr_access_type = raw_type;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rd      <= '0;
      rsp_data    <= '0;
      rsp_illegal <= 1'b0;
      csr_number  <= '0;
      csr_in      <= '0;
      opcode_q    <= '0;
      kind_q      <= '0;
      rs1_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            csr_number <= req_instr[31:20];
            rs1_q      <= req_instr[19:15];
            kind_q     <= req_instr[13:12];
            rsp_rd     <= req_instr[11:7];
            opcode_q   <= req_instr[6:0];
            // funct3[2] selects the immediate (zimm) form of the operand
            csr_in     <= req_instr[14] ? {27'b0, req_instr[19:15]} : req_rs1_value;
            req_ready  <= 1'b0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          rsp_data    <= illegal ? RSP_DATA_ON_ILLEGAL : csr_out;
          rsp_illegal <= illegal;
          rsp_valid   <= 1'b1;
          state       <= RESPOND;
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
